reg_xfer_ctrl: RTL and testbench

Register-transfer sequencer for the four-entry 8-bit register file (AL, BL, CL, DL). It accepts one transfer command at a time over a valid/ready handshake and drives the file's read/write strobes, selects and write data for the required cycles. Supported commands are move, load-immediate, clear and, optionally, a multi-cycle exchange. It sits between instruction decode and the register file.

---
 rtl/reg_ctrl_pkg.sv | 30 +++
 rtl/reg_xfer_ctrl.sv | 150 +++++++++++++++
 tb/tb_reg_xfer_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-transfer sequencer: op codes, register indices
// and FSM state encoding.
package reg_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MOV  = 2'd0,
        OP_LDI  = 2'd1,
        OP_CLR  = 2'd2,
        OP_XCHG = 2'd3
    } op_e;

    localparam logic [1:0] REG_AL = 2'd0;
    localparam logic [1:0] REG_BL = 2'd1;
    localparam logic [1:0] REG_CL = 2'd2;
    localparam logic [1:0] REG_DL = 2'd3;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StExec = 3'd1,
        StX0   = 3'd2,
        StX1   = 3'd3,
        StX2   = 3'd4
    } state_e;

    // Register-file select bus is 8 bits wide; only the low two carry the index.
    function automatic logic [7:0] reg_sel(input logic [1:0] idx);
        return {6'b0, idx};
    endfunction

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer for the AL/BL/CL/DL register file.
// Define REG_XCHG_EN to build the three-cycle exchange; otherwise op 3 reports cmd_err.
module reg_xfer_ctrl
    import reg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src,
    input  logic [7:0] cmd_imm,
    output logic       done,
    output logic       cmd_err,
    output logic       reg_r,
    output logic [7:0] reg_r_select,
    input  logic [7:0] reg_r_line,
    output logic       reg_w,
    output logic [7:0] reg_w_select,
    output logic [7:0] reg_w_line
);

    state_e     state_q, state_d;
    op_e        op_q;
    logic [1:0] dst_q, src_q;
    logic [7:0] imm_q;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       accept;

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = done_q;
    assign cmd_err   = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_MOV;
            dst_q <= 2'd0;
            src_q <= 2'd0;
            imm_q <= 8'h00;
        end else if (accept) begin
            op_q  <= op_e'(cmd_op);
            dst_q <= cmd_dst;
            src_q <= cmd_src;
            imm_q <= cmd_imm;
        end
    end

`ifdef REG_XCHG_EN
    logic [7:0] tmp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmp_q <= 8'h00;
        end else if (state_q == StX0) begin
            tmp_q <= reg_r_line;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        reg_r        = 1'b0;
        reg_r_select = 8'h00;
        reg_w        = 1'b0;
        reg_w_select = 8'h00;
        reg_w_line   = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef REG_XCHG_EN
                    state_d = (op_e'(cmd_op) == OP_XCHG) ? StX0 : StExec;
`else
                    state_d = StExec;
`endif
                end
            end
            StExec: begin
                state_d = StIdle;
                unique case (op_q)
                    OP_MOV: begin
                        reg_r        = 1'b1;
                        reg_r_select = reg_sel(src_q);
                        reg_w        = 1'b1;
                        reg_w_select = reg_sel(dst_q);
                        reg_w_line   = reg_r_line;
                    end
                    OP_LDI: begin
                        reg_w        = 1'b1;
                        reg_w_select = reg_sel(dst_q);
                        reg_w_line   = imm_q;
                    end
                    OP_CLR: begin
                        reg_w        = 1'b1;
                        reg_w_select = reg_sel(dst_q);
                    end
                    // Only reachable without the exchange build: no file access.
                    OP_XCHG: ;
                endcase
            end
`ifdef REG_XCHG_EN
            StX0: begin
                state_d      = StX1;
                reg_r        = 1'b1;
                reg_r_select = reg_sel(dst_q);
            end
            StX1: begin
                state_d      = StX2;
                reg_r        = 1'b1;
                reg_r_select = reg_sel(src_q);
                reg_w        = 1'b1;
                reg_w_select = reg_sel(dst_q);
                reg_w_line   = reg_r_line;
            end
            StX2: begin
                state_d      = StIdle;
                reg_w        = 1'b1;
                reg_w_select = reg_sel(src_q);
                reg_w_line   = tmp_q;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        done_d = (state_q == StExec) || (state_q == StX2);
`ifdef REG_XCHG_EN
        err_d  = 1'b0;
`else
        err_d  = (state_q == StExec) && (op_q == OP_XCHG);
`endif
    end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed self-checking bench for reg_xfer_ctrl with a behavioural register file.
// Follows REG_XCHG_EN to pick exchange or unsupported-op expectations.
module tb_reg_xfer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src;
    logic [7:0] cmd_imm;
    logic       done;
    logic       cmd_err;
    logic       reg_r;
    logic [7:0] reg_r_select;
    logic [7:0] reg_r_line;
    logic       reg_w;
    logic [7:0] reg_w_select;
    logic [7:0] reg_w_line;

    logic [7:0] rf [4];

    int n_checks = 0;
    int n_errors = 0;

    reg_xfer_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dst      (cmd_dst),
        .cmd_src      (cmd_src),
        .cmd_imm      (cmd_imm),
        .done         (done),
        .cmd_err      (cmd_err),
        .reg_r        (reg_r),
        .reg_r_select (reg_r_select),
        .reg_r_line   (reg_r_line),
        .reg_w        (reg_w),
        .reg_w_select (reg_w_select),
        .reg_w_line   (reg_w_line)
    );

    always #5 clk = ~clk;

    assign reg_r_line = rf[reg_r_select[1:0]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else if (reg_w) begin
            rf[reg_w_select[1:0]] <= reg_w_line;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command in an IDLE cycle; returns one step after acceptance (cycle N+1).
    task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [7:0] imm);
        check("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        cmd_imm   = imm;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic ldi(input logic [1:0] dst, input logic [7:0] imm);
        issue(2'd1, dst, 2'd0, imm);
        step();
        check("ldi_done", {31'd0, done}, 32'd1);
    endtask

    int         acc_cyc [4];
    int         idx;
    int         cyc;
    logic       rdy;
    logic [7:0] q_imm [4];

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_dst   = 2'd0;
        cmd_src   = 2'd0;
        cmd_imm   = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_strobes", {30'd0, reg_r, reg_w}, 32'd0);
        check("rst_selects", {16'd0, reg_r_select, reg_w_select}, 32'd0);

        // LDI CL,0x5A
        issue(2'd1, 2'd2, 2'd0, 8'h5A);
        check("ldi_wr", {31'd0, reg_w}, 32'd1);
        check("ldi_rd", {31'd0, reg_r}, 32'd0);
        check("ldi_wsel", {24'd0, reg_w_select}, 32'h02);
        check("ldi_wline", {24'd0, reg_w_line}, 32'h5A);
        check("ldi_busy", {30'd0, cmd_ready, done}, 32'd0);
        step();
        check("ldi_cl", {24'd0, rf[2]}, 32'h5A);
        check("ldi_done_ready", {30'd0, done, cmd_ready}, 32'd3);
        check("ldi_err", {31'd0, cmd_err}, 32'd0);
        check("ldi_idle_w", {31'd0, reg_w}, 32'd0);

        // AL=0x11 then MOV DL,AL issued in the done cycle
        ldi(2'd0, 8'h11);
        issue(2'd0, 2'd3, 2'd0, 8'hEE);
        check("mov_rd", {31'd0, reg_r}, 32'd1);
        check("mov_rsel", {24'd0, reg_r_select}, 32'h00);
        check("mov_wr", {31'd0, reg_w}, 32'd1);
        check("mov_wsel", {24'd0, reg_w_select}, 32'h03);
        check("mov_wline", {24'd0, reg_w_line}, 32'h11);
        step();
        check("mov_dl", {24'd0, rf[3]}, 32'h11);
        check("mov_done", {30'd0, done, cmd_err}, 32'd2);

`ifdef REG_XCHG_EN
        ldi(2'd0, 8'h12);
        ldi(2'd1, 8'h34);
        issue(2'd3, 2'd0, 2'd1, 8'h00);
        check("x0_rd", {23'd0, reg_r, reg_r_select}, {23'd0, 1'b1, 8'h00});
        check("x0_wr", {31'd0, reg_w}, 32'd0);
        step();
        check("x1_rsel", {23'd0, reg_r, reg_r_select}, {23'd0, 1'b1, 8'h01});
        check("x1_w", {15'd0, reg_w, reg_w_select, reg_w_line}, {15'd0, 1'b1, 8'h00, 8'h34});
        step();
        check("x2_rd", {31'd0, reg_r}, 32'd0);
        check("x2_w", {15'd0, reg_w, reg_w_select, reg_w_line}, {15'd0, 1'b1, 8'h01, 8'h12});
        check("x2_done", {31'd0, done}, 32'd0);
        step();
        check("xchg_done", {30'd0, done, cmd_err}, 32'd2);
        check("xchg_al", {24'd0, rf[0]}, 32'h34);
        check("xchg_bl", {24'd0, rf[1]}, 32'h12);
        issue(2'd3, 2'd2, 2'd2, 8'h00);
        repeat (3) step();
        check("xchg_same_done", {31'd0, done}, 32'd1);
        check("xchg_same_cl", {24'd0, rf[2]}, 32'h5A);
`else
        issue(2'd3, 2'd1, 2'd0, 8'h77);
        check("op3_no_access", {30'd0, reg_r, reg_w}, 32'd0);
        check("op3_early", {30'd0, done, cmd_err}, 32'd0);
        step();
        check("op3_done_err", {30'd0, done, cmd_err}, 32'd3);
        check("op3_rf", {rf[0], rf[1], rf[2], rf[3]}, 32'h11005A11);
        step();
        check("op3_err_pulse", {30'd0, done, cmd_err}, 32'd0);
`endif

        // Four LDIs with cmd_valid held high
        q_imm[0] = 8'hA1;
        q_imm[1] = 8'hB2;
        q_imm[2] = 8'hC3;
        q_imm[3] = 8'hD4;
        idx = 0;
        cyc = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        while (idx < 4 && cyc < 40) begin
            cmd_dst = idx[1:0];
            cmd_imm = q_imm[idx];
            rdy = cmd_ready;
            step();
            if (rdy) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            cyc++;
        end
        cmd_valid = 1'b0;
        check("q_all_accepted", idx, 4);
        for (int i = 1; i < 4; i++) check("q_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
        step();
        check("q_rf", {rf[0], rf[1], rf[2], rf[3]}, 32'hA1B2C3D4);

        // Reset asserted mid-cycle while a write is being driven
`ifdef REG_XCHG_EN
        issue(2'd3, 2'd0, 2'd1, 8'h00);
        step();
        check("rst_x1_w", {31'd0, reg_w}, 32'd1);
`else
        issue(2'd1, 2'd3, 2'd0, 8'hFF);
        check("rst_exec_w", {31'd0, reg_w}, 32'd1);
`endif
        #3 reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_flags", {30'd0, done, cmd_err}, 32'd0);
        check("mid_rst_strobes", {30'd0, reg_r, reg_w}, 32'd0);
        check("mid_rst_outs", {8'd0, reg_r_select, reg_w_select, reg_w_line}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("post_rst_rf", {rf[0], rf[1], rf[2], rf[3]}, 32'd0);
        step();
        check("post_rst_w", {31'd0, reg_w}, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        step();
        check("post_rst_rf2", {rf[0], rf[1], rf[2], rf[3]}, 32'd0);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
